// File: rtl/dreg_arb_pkg.sv
// Shared types and helpers for the register-bank write arbiter.
// Latency: none (declarations only).
// Backpressure: n/a.
package dreg_arb_pkg;

    // Widest requester vector the helpers support.
    localparam int MAX_REQ = 16;

    // Top-level controller states.
    typedef enum logic {
        ARB = 1'b0,
        CLR = 1'b1
    } state_t;

    // Round-robin pointer value after reset.
    // It points at the last requester, so the first search starts at index 0.
    function automatic int rr_reset_ptr(input int n_req);
        return n_req - 1;
    endfunction

    // One-hot encode a requester index.
    // Indices at or above n_req give an all-zero vector.
    function automatic logic [MAX_REQ-1:0] onehot(input logic [3:0] index, input int n_req);
        logic [MAX_REQ-1:0] v;
        v = '0;
        if (int'(index) < n_req) begin
            v[index] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/dreg_arb_pick.sv
// Winner picker: first set bit of eligible, searching upward from start and wrapping.
// Latency: purely combinational.
// Backpressure: none; valid drops when nothing is eligible.
module dreg_arb_pick
    import dreg_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] eligible,
    input  logic [IW-1:0]    start,
    output logic             valid,
    output logic [IW-1:0]    winner
);

    int idx;

    // Walk N_REQ positions from start, modulo N_REQ, and keep the first hit.
    always_comb begin
        valid  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(start) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!valid && eligible[idx]) begin
                valid  = 1'b1;
                winner = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/dreg_bank_write_arb.sv
// Shared DEPTHxWIDTH register bank: one arbitrated writer per cycle, plus a one-entry-per-cycle clear sweep.
// Latency: grant and write land on the edge that samples req; rd_data is combinational.
// Backpressure: requests hold until granted; the sweep (busy) holds every request. DREG_ARB_ROUND_ROBIN_EN selects round-robin, otherwise fixed priority.
module dreg_bank_write_arb
    import dreg_arb_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*AW-1:0]    wr_addr,
    input  logic [N_REQ*WIDTH-1:0] wr_data,
    input  logic                   clr,
    output logic [N_REQ-1:0]       gnt,
    output logic                   busy,
    input  logic [AW-1:0]          rd_addr,
    output logic [WIDTH-1:0]       rd_data
);

    localparam int            IW       = $clog2(N_REQ);
    localparam logic [AW-1:0] CNT_LAST = AW'(DEPTH - 1);

    state_t             state;
    state_t             state_nxt;
    logic [AW-1:0]      cnt;
    logic [AW-1:0]      cnt_nxt;
    logic [N_REQ-1:0]   eligible;
    logic [N_REQ-1:0]   gnt_nxt;
    logic [IW-1:0]      pick_start;
    logic [IW-1:0]      win;
    logic               pick_vld;
    logic               wr_en;
    logic               clr_wr;
    logic [AW-1:0]      sel_addr;
    logic [WIDTH-1:0]   sel_data;
    logic               sel_in_range;
    logic               rd_in_range;
    logic [WIDTH-1:0]   bank [DEPTH];

    // A requester granted last cycle sits out this cycle.
    // The masking stops it winning twice in a row while its request is still held.
    assign eligible = req & ~gnt;

`ifdef DREG_ARB_ROUND_ROBIN_EN
    logic [IW-1:0] ptr;

    // Start the search just after the last winner, wrapping at N_REQ.
    assign pick_start = (ptr == IW'(N_REQ - 1)) ? '0 : ptr + IW'(1);

    // Remember the last winner.
    // The pointer holds through idle cycles and the clear sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= IW'(rr_reset_ptr(N_REQ));
        end else if (wr_en) begin
            ptr <= win;
        end
    end
`else
    // Fixed priority: the lowest eligible index always wins.
    assign pick_start = '0;
`endif

    dreg_arb_pick #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_pick (
        .eligible (eligible),
        .start    (pick_start),
        .valid    (pick_vld),
        .winner   (win)
    );

    // Route the winner's address and data onto the single write port.
    assign sel_addr = wr_addr[win*AW +: AW];
    assign sel_data = wr_data[win*WIDTH +: WIDTH];

    // When DEPTH is a power of two, every address is in range.
    // Otherwise the high addresses are dropped on write and read back as zero.
    if (DEPTH == (1 << AW)) begin : g_full_range
        assign sel_in_range = 1'b1;
        assign rd_in_range  = 1'b1;
    end else begin : g_part_range
        assign sel_in_range = int'(sel_addr) < DEPTH;
        assign rd_in_range  = int'(rd_addr) < DEPTH;
    end

    // Next-state logic.
    // In ARB, clr pre-empts any grant and the requests stay pending.
    // CLR walks cnt through every entry, then returns to ARB.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        gnt_nxt   = '0;
        wr_en     = 1'b0;
        clr_wr    = 1'b0;
        case (state)
            ARB: begin
                if (clr) begin
                    state_nxt = CLR;
                    cnt_nxt   = '0;
                end else if (pick_vld) begin
                    wr_en   = 1'b1;
                    gnt_nxt = N_REQ'(onehot(4'(win), N_REQ));
                end
            end
            CLR: begin
                clr_wr  = 1'b1;
                cnt_nxt = cnt + AW'(1);
                if (cnt == CNT_LAST) begin
                    state_nxt = ARB;
                    cnt_nxt   = '0;
                end
            end
            default: state_nxt = ARB;
        endcase
    end

    // State, sweep counter, registered grant and busy flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ARB;
            cnt   <= '0;
            gnt   <= '0;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            gnt   <= gnt_nxt;
            busy  <= (state_nxt == CLR);
        end
    end

    // Bank storage.
    // The sweep and the granted write never happen in the same state, so at most one write lands per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                bank[i] <= '0;
            end
        end else if (clr_wr) begin
            bank[cnt] <= '0;
        end else if (wr_en && sel_in_range) begin
            bank[sel_addr] <= sel_data;
        end
    end

    // Combinational read port; out-of-range addresses read as zero.
    assign rd_data = rd_in_range ? bank[rd_addr] : '0;

endmodule

// File: tb/tb_dreg_bank_write_arb.sv
// Bench for dreg_bank_write_arb. A behavioural model is compared against the DUT every cycle, alongside directed literal checks.
// A second instance with DEPTH=6 covers out-of-range addresses.
// Honours DREG_ARB_ROUND_ROBIN_EN to pick the expected arbitration policy.
module tb_dreg_bank_write_arb;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int D  = 8;
    localparam int A  = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*A-1:0] wr_addr;
    logic [N*W-1:0] wr_data;
    logic           clr;
    logic [A-1:0]   rd_addr;
    logic [N-1:0]   gnt;
    logic           busy;
    logic [W-1:0]   rd_data;
    logic [N-1:0]   gnt6;
    logic           busy6;
    logic [W-1:0]   rd_data6;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #10 clk = ~clk;

    dreg_bank_write_arb #(.N_REQ(N), .WIDTH(W), .DEPTH(D)) u_dut (
        .clk(clk), .rst(rst), .req(req), .wr_addr(wr_addr), .wr_data(wr_data),
        .clr(clr), .gnt(gnt), .busy(busy), .rd_addr(rd_addr), .rd_data(rd_data)
    );

    dreg_bank_write_arb #(.N_REQ(N), .WIDTH(W), .DEPTH(6)) u_dut6 (
        .clk(clk), .rst(rst), .req(req), .wr_addr(wr_addr), .wr_data(wr_data),
        .clr(clr), .gnt(gnt6), .busy(busy6), .rd_addr(rd_addr), .rd_data(rd_data6)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (main DUT) ----------------
    logic [W-1:0] m_bank [D];
    logic [N-1:0] m_gnt;
    int           m_left;
    int           m_ptr;

    always @(posedge clk) begin
        logic [N-1:0] elig;
        int           w;
        int           idx;
        int           addr;
        if (rst) begin
            for (int i = 0; i < D; i++) m_bank[i] = '0;
            m_gnt  = '0;
            m_left = 0;
            m_ptr  = N - 1;
        end else if (m_left > 0) begin
            m_bank[D - m_left] = '0;
            m_left = m_left - 1;
            m_gnt  = '0;
        end else if (clr) begin
            m_left = D;
            m_gnt  = '0;
        end else begin
            elig = req & ~m_gnt;
            w = -1;
            for (int k = 1; k <= N; k++) begin
`ifdef DREG_ARB_ROUND_ROBIN_EN
                idx = (m_ptr + k) % N;
`else
                idx = k - 1;
`endif
                if (w < 0 && elig[idx]) w = idx;
            end
            if (w >= 0) begin
                addr = int'(wr_addr[w*A +: A]);
                if (addr < D) m_bank[addr] = wr_data[w*W +: W];
                m_gnt = N'(1 << w);
                m_ptr = w;
            end else begin
                m_gnt = '0;
            end
        end
    end

    // One compare process, sampling on the falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_gnt", 32'(gnt), 32'(m_gnt));
            chk("model_busy", 32'(busy), 32'(m_left > 0));
            chk("model_rd", 32'(rd_data), 32'(m_bank[rd_addr]));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic nxt();
        @(negedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic [A-1:0] a, input logic [W-1:0] d);
        wr_addr[r*A +: A] = a;
        wr_data[r*W +: W] = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        nxt();
        nxt();
        rst = 1'b0;
    endtask

    task automatic write_one(input int r, input logic [A-1:0] a, input logic [W-1:0] d);
        set_req(r, a, d);
        req = N'(1 << r);
        nxt();
        chk("wr_gnt", 32'(gnt), 32'(1 << r));
        req = '0;
        nxt();
    endtask

    task automatic chk_all_zero(input string name);
        for (int a = 0; a < D; a++) begin
            rd_addr = A'(a);
            #1;
            chk(name, 32'(rd_data), 32'h0);
        end
    endtask

    logic [N-1:0] exp_cont [5];

    initial begin
`ifdef DREG_ARB_ROUND_ROBIN_EN
        exp_cont = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`else
        exp_cont = '{4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'b0001};
`endif
        rst = 1'b1; req = 4'b1111; clr = 1'b0;
        wr_addr = '0; wr_data = '0; rd_addr = '0;

        // Reset held two cycles with every request active.
        nxt();
        chk_en = 1'b1;
        nxt();
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk_all_zero("rst_rd");
        rst = 1'b0;
        req = '0;
        nxt();

        // Single write, then masked while the request is still held.
        set_req(2, 3'd3, 8'hA5);
        req = 4'b0100;
        nxt();
        chk("single_gnt", 32'(gnt), 32'h4);
        rd_addr = 3'd3;
        #1;
        chk("single_rd", 32'(rd_data), 32'hA5);
        nxt();
        chk("single_masked", 32'(gnt), 32'h0);
        req = '0;
        nxt();

        // Contention with all four requesters held.
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, A'(i), W'(8'h10 + i));
        req = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            nxt();
            chk("cont_gnt", 32'(gnt), 32'(exp_cont[c]));
        end
        req = '0;
        nxt();

        // Clear sweep pulsed together with a request.
        for (int a = 0; a < D; a++) write_one(2, A'(a), W'(8'h20 + a));
        set_req(0, 3'd0, 8'h77);
        req = 4'b0001;
        clr = 1'b1;
        nxt();
        clr = 1'b0;
        chk("clr_gnt", 32'(gnt), 32'h0);
        chk("clr_busy", 32'(busy), 32'h1);
        for (int c = 1; c < D; c++) begin
            nxt();
            chk("clr_busy_hold", 32'(busy), 32'h1);
            chk("clr_gnt_hold", 32'(gnt), 32'h0);
        end
        nxt();
        chk("clr_busy_fall", 32'(busy), 32'h0);
        chk("clr_gnt_fall", 32'(gnt), 32'h0);
        chk_all_zero("clr_rd");
        nxt();
        chk("clr_first_gnt", 32'(gnt), 32'h1);
        req = '0;
        nxt();

        // Reset during the fourth cycle of a sweep.
        for (int a = 0; a < D; a++) write_one(2, A'(a), W'(8'h40 + a));
        clr = 1'b1;
        nxt();
        clr = 1'b0;
        nxt();
        nxt();
        nxt();
        rst = 1'b1;
        nxt();
        rst = 1'b0;
        chk("mid_rst_busy", 32'(busy), 32'h0);
        chk("mid_rst_gnt", 32'(gnt), 32'h0);
        chk_all_zero("mid_rst_rd");
        req = 4'b1111;
        nxt();
        chk("mid_rst_ptr", 32'(gnt), 32'h1);
        req = '0;
        nxt();

        // Out-of-range write and read on the DEPTH=6 instance.
        do_reset();
        write_one(0, 3'd2, 8'h3C);
        rd_addr = 3'd2;
        #1;
        chk("oor_pre_rd", 32'(rd_data6), 32'h3C);
        set_req(0, 3'd7, 8'hFF);
        req = 4'b0001;
        nxt();
        chk("oor_gnt", 32'(gnt6), 32'h1);
        chk("oor_busy", 32'(busy6), 32'h0);
        req = '0;
        for (int a = 0; a < D; a++) begin
            rd_addr = A'(a);
            #1;
            chk("oor_rd", 32'(rd_data6), (a == 2) ? 32'h3C : 32'h0);
        end
        nxt();

        // Randomised traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            rst     = ($urandom_range(99) == 0);
            clr     = ($urandom_range(29) == 0);
            req     = N'($urandom);
            wr_addr = (N*A)'($urandom);
            wr_data = $urandom;
            rd_addr = A'($urandom);
            nxt();
        end
        rst = 1'b0;
        clr = 1'b0;
        req = '0;
        nxt();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
